// File: rtl/clk_div_meter.sv
// clk_div_meter: measures period and high time of a selected divided clock in clkIn cycles
module clk_div_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clkIn,
  input  logic             rst,
  input  logic [5:0]       div_in,
  input  logic [2:0]       sel,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ARM, HIGH, LOW, DONE} state_t;
  state_t           state;
  logic [2:0]       sel_q;
  logic [1:0]       sync;
  logic             s_d;
  logic [CNT_W-1:0] cnt;
  logic [TW-1:0]    tcnt;
  logic [7:0]       src;
  logic             s, rise, fall, tmo;
  logic [CNT_W-1:0] cnt_inc;
  assign src     = {2'b00, div_in};
  assign s       = sync[1];
  assign rise    = s & ~s_d;
  assign fall    = ~s & s_d;
  assign tmo     = (state inside {ARM, HIGH, LOW}) && (tcnt == TW'(TIMEOUT - 1));
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  always_ff @(posedge clkIn or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sel_q     <= '0;
      sync      <= '0;
      s_d       <= 1'b0;
      cnt       <= '0;
      tcnt      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      period    <= '0;
      high_time <= '0;
    end else begin
      sync <= {sync[0], src[sel_q]};
      s_d  <= s;
      done <= 1'b0;
      if (state inside {ARM, HIGH, LOW}) tcnt <= tcnt + 1'b1;
      if (tmo) begin
        state     <= DONE;
        timeout   <= 1'b1;
        period    <= '0;
        high_time <= '0;
        done      <= 1'b1;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            sel_q   <= sel;
            tcnt    <= '0;
            timeout <= 1'b0;
            busy    <= 1'b1;
            state   <= ARM;
          end
          // s/s_d still carry the previous selection for the first cycles of ARM
          ARM: if (rise && tcnt >= TW'(3)) begin
            cnt   <= CNT_W'(1);
            state <= HIGH;
          end
          HIGH: begin
            cnt <= cnt_inc;
            if (fall) begin
              high_time <= cnt;
              state     <= LOW;
            end
          end
          LOW: begin
            cnt <= cnt_inc;
            if (rise) begin
              period <= cnt;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= DONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_clk_div_meter.sv
// tb_clk_div_meter: directed checks of clk_div_meter against bench-generated divided clocks
module tb_clk_div_meter;
  logic        clkIn = 1'b0;
  logic        rst;
  logic [5:0]  div_in = '0;
  logic [2:0]  sel;
  logic        start;
  logic        busy, done, timeout;
  logic [15:0] period, high_time;
  int          checks = 0;
  int          errors = 0;
  int          c = 0;

  clk_div_meter dut (
    .clkIn(clkIn), .rst(rst), .div_in(div_in), .sel(sel), .start(start),
    .busy(busy), .done(done), .timeout(timeout), .period(period), .high_time(high_time)
  );

  always #5 clkIn = ~clkIn;

  function automatic logic [5:0] gen(input int n);
    logic d5;
    d5 = (n % 5 < 2) || (n % 5 == 2 && (n / 5) % 2 == 1);
    return {d5, n % 28 < 14, n % 16 < 8, n % 8 < 4, n % 4 < 2, n % 2 < 1};
  endfunction

  initial forever begin
    @(posedge clkIn);
    #2;
    c++;
    div_in = gen(c);
  end

  task automatic run(input logic [2:0] s, output logic ok, output int lat);
    int b;
    ok = 1'b0;
    b = -1;
    lat = 0;
    @(negedge clkIn);
    sel = s;
    start = 1'b1;
    for (int cyc = 1; cyc <= 2000 && !ok; cyc++) begin
      @(negedge clkIn);
      start = 1'b0;
      sel = 3'd7;
      if (busy && b < 0) b = cyc;
      if (done) begin
        ok = 1'b1;
        lat = cyc - b;
      end
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({busy, done, timeout, period, high_time} !== '0) begin
      errors++;
      $display("FAIL reset: got busy=%0b done=%0b to=%0b per=%0d hi=%0d, exp all 0", busy, done, timeout, period, high_time);
    end
  endtask

  task automatic test_div2;
    logic ok;
    int lat;
    run(3'd0, ok, lat);
    checks++;
    if (!ok || lat > 12) begin
      errors++;
      $display("FAIL div2_latency: got ok=%0b lat=%0d, exp done within 12", ok, lat);
    end
    checks++;
    if ({timeout, period, high_time} !== {1'b0, 16'd2, 16'd1}) begin
      errors++;
      $display("FAIL div2_result: got to=%0b per=%0d hi=%0d, exp 0/2/1", timeout, period, high_time);
    end
    @(negedge clkIn);
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL div2_pulse: got done=%0b busy=%0b, exp 0 0", done, busy);
    end
  endtask

  task automatic test_divs;
    logic [2:0] s [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    int ep [4] = '{4, 8, 16, 28};
    int eh [4] = '{2, 4, 8, 14};
    logic ok;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run(s[i], ok, lat);
      checks++;
      if (!ok || timeout !== 1'b0 || period !== 16'(ep[i]) || high_time !== 16'(eh[i])) begin
        errors++;
        $display("FAIL div_sel%0d: got ok=%0b to=%0b per=%0d hi=%0d, exp 0/%0d/%0d", s[i], ok, timeout, period, high_time, ep[i], eh[i]);
      end
    end
  endtask

  task automatic test_div5;
    logic ok;
    int lat;
    for (int i = 0; i < 10; i++) begin
      run(3'd5, ok, lat);
      checks++;
      if (!ok || timeout !== 1'b0 || period !== 16'd5 || !(high_time inside {16'd2, 16'd3})) begin
        errors++;
        $display("FAIL div5_run%0d: got ok=%0b to=%0b per=%0d hi=%0d, exp 0/5/2or3", i, ok, timeout, period, high_time);
      end
    end
  endtask

  task automatic test_timeout;
    logic [2:0] s [2] = '{3'd6, 3'd7};
    logic ok;
    int lat;
    for (int i = 0; i < 2; i++) begin
      run(s[i], ok, lat);
      checks++;
      if (!ok || lat != 1024) begin
        errors++;
        $display("FAIL timeout_lat_sel%0d: got ok=%0b lat=%0d, exp 1024", s[i], ok, lat);
      end
      checks++;
      if ({timeout, period, high_time} !== {1'b1, 16'd0, 16'd0}) begin
        errors++;
        $display("FAIL timeout_result_sel%0d: got to=%0b per=%0d hi=%0d, exp 1/0/0", s[i], timeout, period, high_time);
      end
    end
  endtask

  task automatic test_back_to_back;
    int ndone = 0;
    logic [15:0] p = '0, h = '0;
    logic t = 1'b1;
    @(negedge clkIn);
    sel = 3'd3;
    start = 1'b1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clkIn);
      sel = 3'd0;
      start = busy && ndone == 0 && cyc % 3 == 0;
      if (done) begin
        if (ndone == 0) begin
          p = period;
          h = high_time;
          t = timeout;
        end
        ndone++;
      end
    end
    start = 1'b0;
    checks++;
    if (ndone != 1 || {t, p, h} !== {1'b0, 16'd16, 16'd8}) begin
      errors++;
      $display("FAIL back_to_back: got dones=%0d to=%0b per=%0d hi=%0d, exp 1/0/16/8", ndone, t, p, h);
    end
  endtask

  task automatic test_reset_mid;
    int ndone = 0;
    logic ok;
    int lat;
    @(negedge clkIn);
    sel = 3'd4;
    start = 1'b1;
    @(negedge clkIn);
    start = 1'b0;
    repeat (4) @(negedge clkIn);
    while (c % 28 != 0) @(negedge clkIn);
    while (c % 28 != 20) @(negedge clkIn);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: got busy=%0b, exp 1", busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, timeout, period, high_time} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got busy=%0b done=%0b to=%0b per=%0d hi=%0d, exp all 0", busy, done, timeout, period, high_time);
    end
    repeat (3) @(negedge clkIn);
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clkIn);
      if (done || busy) ndone++;
    end
    checks++;
    if (ndone != 0 || {period, high_time} !== '0) begin
      errors++;
      $display("FAIL mid_quiet: got active=%0d per=%0d hi=%0d, exp 0/0/0", ndone, period, high_time);
    end
    run(3'd4, ok, lat);
    checks++;
    if (!ok || {timeout, period, high_time} !== {1'b0, 16'd28, 16'd14}) begin
      errors++;
      $display("FAIL mid_recover: got ok=%0b to=%0b per=%0d hi=%0d, exp 0/28/14", ok, timeout, period, high_time);
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    sel = 3'd0;
    repeat (3) @(negedge clkIn);
    test_reset;
    rst = 1'b1;
    @(negedge clkIn);
    test_div2;
    test_divs;
    test_div5;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
